// File: rtl/threshold_trigger_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : trigger_pkg
//  Description : Shared types and constants for the threshold self-trigger:
//                FSM state encoding, lane geometry and trigger-level helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package trigger_pkg;

  localparam int LANE_WIDTH = 16;
  localparam int LANE_COUNT = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_HOLDOFF = 2'd2
  } trig_state_e;

  // Trigger level as floor(threshold% of positive full scale)
  function automatic int trig_level(input int threshold, input int res);
    return (threshold * (1 << (res - 1))) / 100;
  endfunction

endpackage
`default_nettype wire

// File: rtl/threshold_trigger_if.sv
`default_nettype none
// ============================================================================
//  Module      : threshold_trigger_if
//  Description : AXI4-Stream sample-beat bundle observed by the trigger.
//                The trigger only watches the stream, so every signal is an
//                input on the slave side (TREADY is observed, not driven).
//  Revision    : 1.0 - initial release
// ============================================================================
interface threshold_trigger_if #(
  parameter int TDATA_WIDTH = 128
);
  logic [TDATA_WIDTH-1:0] TDATA;
  logic                   TVALID;
  logic                   TREADY;

  modport master (output TDATA, output TVALID, output TREADY);
  modport slave  (input  TDATA, input  TVALID, input  TREADY);
endinterface
`default_nettype wire

// File: rtl/threshold_trigger_lane_comparator.sv
`default_nettype none
// ============================================================================
//  Module      : lane_comparator
//  Description : Parallel signed compare of every lane's MSB-justified sample
//                against the trigger level, OR-reduced to one combinational
//                "over" flag. The parent registers the result.
//  Revision    : 1.0 - initial release
// ============================================================================
module lane_comparator
  import trigger_pkg::*;
#(
  parameter int LANES     = LANE_COUNT,
  parameter int RES_WIDTH = 12,
  parameter int LEVEL     = 204
) (
  input  logic [LANES*LANE_WIDTH-1:0] i_tdata,
  output logic                        o_over
);

  // One extra bit so a level of exactly +full-scale is still representable
  localparam logic signed [RES_WIDTH:0] C_LEVEL = (RES_WIDTH + 1)'(LEVEL);

  logic [LANES-1:0] w_lane_over;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [RES_WIDTH-1:0] w_sample;
    assign w_sample       = i_tdata[k*LANE_WIDTH + LANE_WIDTH - 1 -: RES_WIDTH];
    assign w_lane_over[k] = $signed({w_sample[RES_WIDTH-1], w_sample}) >= C_LEVEL;
  end

  // Padding bits below the ADC resolution carry no sample information
  if (LANE_WIDTH > RES_WIDTH) begin : g_pad
    localparam int C_PAD = LANE_WIDTH - RES_WIDTH;
    logic [LANES*C_PAD-1:0] w_unused_pad;
    for (genvar k = 0; k < LANES; k++) begin : g_pad_lane
      assign w_unused_pad[k*C_PAD +: C_PAD] = i_tdata[k*LANE_WIDTH +: C_PAD];
    end
  end

  assign o_over = |w_lane_over;

endmodule
`default_nettype wire

// File: rtl/threshold_trigger.sv
`default_nettype none
// ============================================================================
//  Module      : threshold_trigger
//  Description : Self-trigger for the minimum-trigger path. Detects a sample
//                at or above the threshold on a taken beat, then raises
//                TRIGGERD_FLAG for POST_ACQUI_LEN taken beats with the beat's
//                time stamp, followed by a hold-off. Hits while the
//                downstream FIFO is full are dropped and counted.
//                Macro THRESHOLD_TRIGGER_EDGE_EN: rising-edge qualification
//                (a hit requires the previous taken beat to be below level).
//  Revision    : 1.0 - initial release
// ============================================================================
module threshold_trigger
  import trigger_pkg::*;
#(
  parameter int THRESHOLD            = 10,
  parameter int PRE_ACQUI_LEN        = 12,
  parameter int POST_ACQUI_LEN       = 38,
  parameter int HOLDOFF_LEN          = PRE_ACQUI_LEN,
  parameter int TIME_STAMP_WIDTH     = 16,
  parameter int ADC_RESOLUTION_WIDTH = 12,
  parameter int S_AXIS_TDATA_WIDTH   = 128
) (
  input  logic                        AXIS_ACLK,
  input  logic                        AXIS_ARESETN,
  threshold_trigger_if.slave          S_AXIS,
  input  logic                        I_FIFO_FULL,
  output logic                        TRIGGERD_FLAG,
  output logic [TIME_STAMP_WIDTH-1:0] TIME_STAMP,
  output logic [15:0]                 O_DROP_CNT
);

  localparam int C_LANES      = S_AXIS_TDATA_WIDTH / LANE_WIDTH;
  localparam int C_TRIG_LEVEL = trig_level(THRESHOLD, ADC_RESOLUTION_WIDTH);
  localparam int C_WIN_W      = (POST_ACQUI_LEN > 1) ? $clog2(POST_ACQUI_LEN) : 1;
  localparam int C_HOLD_W     = (HOLDOFF_LEN > 1) ? $clog2(HOLDOFF_LEN) : 1;
  localparam logic [C_WIN_W-1:0]  C_WIN_LAST  = C_WIN_W'(POST_ACQUI_LEN - 1);
  localparam logic [C_HOLD_W-1:0] C_HOLD_LAST =
    C_HOLD_W'((HOLDOFF_LEN > 0) ? HOLDOFF_LEN - 1 : 0);

  localparam logic [1:0] C_IDLE    = ST_IDLE;
  localparam logic [1:0] C_ACQUIRE = ST_ACQUIRE;
  localparam logic [1:0] C_HOLDOFF = ST_HOLDOFF;

  logic                        w_take;
  logic                        w_over;
  logic                        w_hit;
  logic [TIME_STAMP_WIDTH-1:0] r_ts_cnt;
  logic                        r_hit;
  logic [TIME_STAMP_WIDTH-1:0] r_ts_hit;
  logic [1:0]                  r_state;
  logic [C_WIN_W-1:0]          r_win_cnt;
  logic [C_HOLD_W-1:0]         r_hold_cnt;
  logic                        r_flag;
  logic [TIME_STAMP_WIDTH-1:0] r_stamp;
  logic [15:0]                 r_drop;

  assign w_take = S_AXIS.TVALID & S_AXIS.TREADY;

  lane_comparator #(
    .LANES     (C_LANES),
    .RES_WIDTH (ADC_RESOLUTION_WIDTH),
    .LEVEL     (C_TRIG_LEVEL)
  ) u_lane_comparator (
    .i_tdata (S_AXIS.TDATA),
    .o_over  (w_over)
  );

`ifdef THRESHOLD_TRIGGER_EDGE_EN
  logic r_prev_over;

  // Remember whether the last taken beat was already over the level
  always_ff @(posedge AXIS_ACLK) begin
    if (!AXIS_ARESETN) begin
      r_prev_over <= 1'b0;
    end else if (w_take) begin
      r_prev_over <= w_over;
    end
  end

  assign w_hit = w_take & w_over & ~r_prev_over;
`else
  assign w_hit = w_take & w_over;
`endif

  // Free-running stamp counter and stage-1 hit/stamp capture
  always_ff @(posedge AXIS_ACLK) begin
    if (!AXIS_ARESETN) begin
      r_ts_cnt <= '0;
      r_hit    <= 1'b0;
      r_ts_hit <= '0;
    end else begin
      r_ts_cnt <= r_ts_cnt + TIME_STAMP_WIDTH'(1);
      r_hit    <= w_hit;
      r_ts_hit <= r_ts_cnt;
    end
  end

  // Window FSM: arm on a registered hit, count taken beats, then hold off
  always_ff @(posedge AXIS_ACLK) begin
    if (!AXIS_ARESETN) begin
      r_state    <= C_IDLE;
      r_win_cnt  <= '0;
      r_hold_cnt <= '0;
      r_flag     <= 1'b0;
      r_stamp    <= '0;
      r_drop     <= '0;
    end else begin
      case (r_state)
        C_IDLE: begin
          if (r_hit) begin
            if (!I_FIFO_FULL) begin
              r_state   <= C_ACQUIRE;
              r_flag    <= 1'b1;
              r_stamp   <= r_ts_hit;
              r_win_cnt <= '0;
            end else if (r_drop != 16'hFFFF) begin
              r_drop <= r_drop + 16'd1;
            end
          end
        end
        C_ACQUIRE: begin
          if (w_take) begin
            if (r_win_cnt == C_WIN_LAST) begin
              r_flag     <= 1'b0;
              r_win_cnt  <= '0;
              r_hold_cnt <= '0;
              // A zero hold-off returns straight to arming
              r_state    <= (HOLDOFF_LEN == 0) ? C_IDLE : C_HOLDOFF;
            end else begin
              r_win_cnt <= r_win_cnt + C_WIN_W'(1);
            end
          end
        end
        C_HOLDOFF: begin
          if (r_hold_cnt == C_HOLD_LAST) begin
            r_state    <= C_IDLE;
            r_hold_cnt <= '0;
          end else begin
            r_hold_cnt <= r_hold_cnt + C_HOLD_W'(1);
          end
        end
        default: begin
          r_state <= C_IDLE;
          r_flag  <= 1'b0;
        end
      endcase
    end
  end

  assign TRIGGERD_FLAG = r_flag;
  assign TIME_STAMP    = r_stamp;
  assign O_DROP_CNT    = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_threshold_trigger.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_threshold_trigger
//  Description : Self-checking bench for threshold_trigger: a cycle-level
//                behavioural model checked every cycle, plus directed
//                literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_threshold_trigger;

  localparam int POST  = 38;
  localparam int HOLD  = 12;
  localparam int LEVEL = 10 * 2048 / 100;   // 204

  logic        clk  = 1'b0;
  logic        rstn = 1'b0;
  logic        full = 1'b0;
  logic        flag;
  logic [15:0] stamp;
  logic [15:0] drop;
  int          total = 0;
  int          bad   = 0;
  bit          chk_en = 1'b0;

  always #5 clk = ~clk;

  threshold_trigger_if #(.TDATA_WIDTH(128)) s_axis ();

  threshold_trigger #(
    .THRESHOLD(10), .PRE_ACQUI_LEN(12), .POST_ACQUI_LEN(POST), .HOLDOFF_LEN(HOLD),
    .TIME_STAMP_WIDTH(16), .ADC_RESOLUTION_WIDTH(12), .S_AXIS_TDATA_WIDTH(128)
  ) dut (
    .AXIS_ACLK(clk), .AXIS_ARESETN(rstn), .S_AXIS(s_axis), .I_FIFO_FULL(full),
    .TRIGGERD_FLAG(flag), .TIME_STAMP(stamp), .O_DROP_CNT(drop)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, got, exp, $time);
    end
  endtask

  // Signed 12-bit sample value held in the top of a 16-bit lane
  function automatic int lane_val(input logic [127:0] d, input int k);
    int u;
    u = int'(d[k*16 +: 16]) / 16;
    if (u >= 2048) u = u - 4096;
    return u;
  endfunction

  // ---------------- behavioural model ----------------
  int m_ts = 0, m_ts_d = 0, m_stamp = 0, m_drop = 0, m_beats = 0, m_block = 0;
  bit m_flag = 0, m_hit_d = 0, m_prev = 0;

  always @(posedge clk) begin
    bit take, over, hit;
    take = s_axis.TVALID && s_axis.TREADY;
    over = 1'b0;
    for (int k = 0; k < 8; k++)
      if (lane_val(s_axis.TDATA, k) >= LEVEL) over = 1'b1;
    if (!rstn) begin
      m_ts <= 0; m_ts_d <= 0; m_stamp <= 0; m_drop <= 0; m_beats <= 0;
      m_block <= 0; m_flag <= 0; m_hit_d <= 0; m_prev <= 0;
    end else begin
      hit = take && over;
`ifdef THRESHOLD_TRIGGER_EDGE_EN
      hit = hit && !m_prev;
`endif
      if (take) m_prev <= over;
      m_hit_d <= hit;
      m_ts_d  <= m_ts;
      m_ts    <= (m_ts + 1) % 65536;
      if (m_flag) begin
        if (take) begin
          if (m_beats + 1 == POST) begin
            m_flag <= 0; m_block <= HOLD; m_beats <= 0;
          end else begin
            m_beats <= m_beats + 1;
          end
        end
      end else if (m_block > 0) begin
        m_block <= m_block - 1;
      end else if (m_hit_d) begin
        if (!full) begin
          m_flag <= 1; m_stamp <= m_ts_d; m_beats <= 0;
        end else if (m_drop < 65535) begin
          m_drop <= m_drop + 1;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_flag",  32'(flag),  32'(m_flag));
      check("model_stamp", 32'(stamp), 32'(m_stamp));
      check("model_drop",  32'(drop),  32'(m_drop));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [127:0] d, input logic v);
    s_axis.TDATA  = d;
    s_axis.TVALID = v;
  endtask

  task automatic set_beat(input int lane, input logic [15:0] val);
    logic [127:0] d;
    d = '0;
    d[lane*16 +: 16] = val;
    drive(d, 1'b1);
  endtask

  task automatic idle(input int n);
    drive('0, 1'b0);
    repeat (n) tick();
  endtask

  task automatic run(input int n);
    drive('0, 1'b1);
    repeat (n) tick();
  endtask

  // After this task the bench sits in cycle 0 (stamp counter = 0)
  task automatic do_reset();
    drive('0, 1'b0);
    full = 1'b0;
    rstn = 1'b0;
    tick();
    chk_en = 1'b1;
    rstn = 1'b1;
  endtask

  logic [15:0] vals [4] = '{16'h0CC0, 16'h0CB0, 16'hF000, 16'h7FF0};
  bit          expv [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
  bit          rdy  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    int cnt, hi, rises, first_rise, second_rise, cyc;
    bit last;
    logic [15:0] drop_before;
    s_axis.TREADY = 1'b1;
    drive('0, 1'b0);

    // Basic trigger: lane 3 = 205 in cycle 10
    do_reset();
    check("reset_flag", 32'(flag), 0);
    check("reset_stamp", 32'(stamp), 0);
    check("reset_drop", 32'(drop), 0);
    idle(10);
    set_beat(3, 16'h0CD0);
    tick();                                    // cycle 11
    drive('0, 1'b1);
    check("t1_flag_c11", 32'(flag), 0);
    tick();                                    // cycle 12
    check("t1_flag_c12", 32'(flag), 1);
    check("t1_stamp", 32'(stamp), 10);
    repeat (37) tick();                        // cycle 49
    check("t1_flag_c49", 32'(flag), 1);
    tick();                                    // cycle 50
    check("t1_flag_c50", 32'(flag), 0);
    idle(30);

    // Level boundaries, negative value, and an over-level beat not taken
    for (int i = 0; i < 4; i++) begin
      do_reset();
      idle(3);
      s_axis.TREADY = rdy[i];
      set_beat(i, vals[i]);
      tick();
      s_axis.TREADY = 1'b1;
      drive('0, 1'b1);
      tick();
      check($sformatf("level_case%0d", i), 32'(flag), 32'(expv[i]));
      run(60);
    end

    // TVALID every other cycle; second hit mid-window must be ignored
    do_reset();
    idle(3);
    set_beat(5, 16'h0CD0);
    tick();
    drop_before = drop;
    cnt = 0; hi = 0;
    for (int c = 0; c < 200; c++) begin
      if (c == 41) set_beat(1, 16'h7000);
      else drive('0, 1'(c % 2));
      if (flag) begin
        hi++;
        if (s_axis.TVALID) cnt++;
      end
      tick();
    end
    check("gap_beats", 32'(cnt), POST);
    check("gap_cycles", 32'(hi), 2 * POST - 1);
    check("gap_drop", 32'(drop), 32'(drop_before));

    // FIFO full: three dropped hits, then full during a window is ignored
    do_reset();
    full = 1'b1;
    hi = 0;
    for (int h = 0; h < 3; h++) begin
      run(2);
      set_beat(h, 16'h0D00);
      tick();
    end
    drive('0, 1'b1);
    for (int c = 0; c < 20; c++) begin
      if (flag) hi++;
      tick();
    end
    check("full_no_flag", 32'(hi), 0);
    check("full_drop3", 32'(drop), 3);
    full = 1'b0;
    set_beat(7, 16'h0D00);
    tick();
    drive('0, 1'b1);
    tick();
    check("full_win_start", 32'(flag), 1);
    full = 1'b1;
    cnt = 0;
    for (int c = 0; c < 60; c++) begin
      if (flag) cnt++;
      tick();
    end
    check("full_win_beats", 32'(cnt), POST);
    check("full_drop_hold", 32'(drop), 3);
    full = 1'b0;
    run(30);

    // Sustained over-level signal on all lanes
    do_reset();
    drive({8{16'h7FF0}}, 1'b1);
    rises = 0; first_rise = -1; second_rise = -1; last = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (flag && !last) begin
        rises++;
        if (first_rise < 0) first_rise = c;
        else if (second_rise < 0) second_rise = c;
      end
      last = flag;
      tick();
    end
`ifdef THRESHOLD_TRIGGER_EDGE_EN
    check("sustained_pulses", 32'(rises), 1);
`else
    // High POST cycles, then HOLD hold-off cycles plus one IDLE cycle
    check("sustained_period", 32'(second_rise - first_rise), POST + HOLD + 1);
`endif
    run(60);

    // Reset in the middle of a window
    do_reset();
    idle(2);
    set_beat(0, 16'h0D00);
    tick();
    run(20);
    check("rst_pre_flag", 32'(flag), 1);
    rstn = 1'b0;
    tick();
    check("rst_flag", 32'(flag), 0);
    check("rst_stamp", 32'(stamp), 0);
    rstn = 1'b1;                               // cycle 0 again
    idle(5);
    set_beat(2, 16'h0D00);
    tick();
    drive('0, 1'b1);
    tick();
    check("rst_restart_stamp", 32'(stamp), 5);
    run(60);

    // Stamp counter wrap: hit in the cycle the counter reads 0 again
    do_reset();
    idle(65536);
    set_beat(4, 16'h0D00);
    tick();
    drive('0, 1'b1);
    tick();
    check("wrap_flag", 32'(flag), 1);
    check("wrap_stamp", 32'(stamp), 0);
    run(60);

    cyc = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
